axi_lite_intc: RTL and testbench
================================

# axi_lite_intc

Parametrised AXI4-Lite interrupt controller slave with up to 32 interrupt sources, per-source edge/level mode and polarity, and one interrupt output. It sits behind the processor's AXI4-Lite interconnect. Its register map at offsets 0x00–0x10 keeps the existing single-source interrupt slave's layout, so current drivers and BFM tests run unchanged. It adds mode and polarity registers, an unmapped-address error response and an optional input synchroniser.

## Interface
- NUM_INTR, 1: number of interrupt sources, 1..32.
- ADDR_WIDTH, 5: AXI address width; word address is ADDR[4:2].
- IRQ_ACTIVE_STATE, 1: irq asserted level (1 = high, 0 = low).
- ACLK  in  1  the block's only clock; all logic is on its rising edge.
- ARESETN  in  1  reset, asynchronous and active-low.
- intr_in  in  NUM_INTR  raw interrupt sources.
- irq  out  1  interrupt to the processor.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA(32)/WSTRB(4)/WVALID/WREADY, BRESP(2)/BVALID/BREADY: AXI4-Lite write channels.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA(32)/RRESP(2)/RVALID/RREADY: AXI4-Lite read channels. AWPROT and ARPROT are ignored.

## Operation
- Register map. Bits at or above NUM_INTR read 0 and ignore writes.
  - 0x00 GIE: bit0 global enable, RW.
  - 0x04 IER: interrupt enable, RW.
  - 0x08 ISR: raw status, RO.
  - 0x0C IAR: acknowledge, write-1-to-clear ISR, reads 0.
  - 0x10 IPR: pending, RO, equals ISR & IER.
  - 0x14 MODE: RW; 1 = edge, 0 = level.
  - 0x18 POL: RW; 1 = rising edge or high level, 0 = falling edge or low level.
- WSTRB is honoured per byte for GIE, IER, IAR, MODE and POL.
- Unmapped offsets 0x1C: reads return 0 with RRESP=SLVERR (2'b10); writes have no effect and return BRESP=SLVERR. All mapped accesses return OKAY.
- Source event, per bit i, with s = intr_in (or its synchronised copy) and q = s delayed one cycle:
  - edge mode: event when (POL ? s&~q : ~s&q);
  - level mode: event when s==POL.
- ISR[i] is set on an event and cleared by an IAR write with bit i = 1. If set and clear occur in the same cycle, set wins.
- In level mode, a still-active source re-sets ISR on the cycle after the acknowledge.
- irq_int = GIE & |(ISR & IER), registered; irq = irq_int when IRQ_ACTIVE_STATE=1, ~irq_int otherwise.
- Edge detection is disarmed for the first cycle after reset release, so a source already active across reset raises no edge event. Level mode is not affected.

## Timing
- Reset values:
  - all registers 0, q = 0;
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0;
  - BRESP, RRESP, RDATA = 0;
  - irq = ~IRQ_ACTIVE_STATE (inactive).
- Write handshake:
  - Accepted only when AWVALID and WVALID are both high and BVALID is low.
  - AWREADY and WREADY pulse together for one cycle; the register updates on the same edge.
  - BVALID rises on the next edge and holds until BREADY.
  - No new write is accepted while BVALID is high.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RVALID and RDATA follow on the next edge, and hold stable until RREADY.
- Writes and reads proceed independently. A read of ISR or IPR in the cycle a write updates them returns the pre-write value.
- Latency without sync:
  - source change before edge k sets ISR after edge k;
  - irq asserts after edge k+1;
  - an IAR write clears irq one edge after the write handshake edge.
- Reset asserted mid-transaction drops all handshakes immediately. A half-done write is lost.

## Configuration
- INTC_SYNC_EN defined: intr_in passes through a two-flop synchroniser reset to 0, which adds 2 cycles to every source-to-ISR latency.
- INTC_SYNC_EN undefined: intr_in is used directly and must be synchronous to ACLK.

## Structure
- Package axi_lite_intc_pkg holds:
  - register offset constants;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the data width constant of 32.
- Sub-module axi_lite_intc_src, instanced NUM_INTR times, holds one bit's sync/delay, edge/level detect and ISR bit with set-over-clear priority.
- The top level holds the AXI handshake, the registers and the irq reduction.

## Test plan
- Reset, then read all 7 registers → every read 0x00000000, RRESP=OKAY, irq inactive.
- NUM_INTR=4: write GIE=1, IER=0xF, MODE=0xF, POL=0xF, then pulse intr_in[2] high for 1 cycle → ISR=0x4, IPR=0x4, irq active 2 cycles after the pulse. Write IAR=0x4 → ISR=0, irq inactive.
- Level mode, POL[0]=0, intr_in[0] held low, then write IAR=0x1 → ISR[0] reads 1 again; release the input high and ack → ISR=0.
- Set IER=0x1 with an ISR=0x2 event pending → IPR=0, irq inactive; then write IER=0x3 → irq active.
- Edge event on bit 1 in the same cycle as an IAR=0x2 write → ISR[1]=1 afterwards.
- Write to and read from 0x1C → BRESP=SLVERR, RRESP=SLVERR, RDATA=0. Hold BREADY low for 5 cycles → BVALID held, and a second write is not accepted until BREADY.

Source files
------------

// File: rtl/axi_lite_intc_pkg.sv
// axi_lite_intc_pkg
// Shared constants for the AXI4-Lite interrupt controller:
//   - word indices (ADDR[4:2]) of the register map;
//   - AXI response codes;
//   - register data width;
//   - byte-strobe helpers used by the write path.
package axi_lite_intc_pkg;

  localparam int DATA_WIDTH = 32;

  // Word indices (byte offset >> 2)
  localparam logic [2:0] REG_GIE  = 3'd0; // 0x00
  localparam logic [2:0] REG_IER  = 3'd1; // 0x04
  localparam logic [2:0] REG_ISR  = 3'd2; // 0x08
  localparam logic [2:0] REG_IAR  = 3'd3; // 0x0C
  localparam logic [2:0] REG_IPR  = 3'd4; // 0x10
  localparam logic [2:0] REG_MODE = 3'd5; // 0x14
  localparam logic [2:0] REG_POL  = 3'd6; // 0x18

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [3:0] strb);
    logic [DATA_WIDTH-1:0] m;
    m = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_lite_intc_src.sv
// axi_lite_intc_src
// One interrupt source: optional two-flop synchroniser, one-cycle delay,
// edge/level event detection and the ISR bit (set has priority over clear).
// Build option: INTC_SYNC_EN adds the synchroniser in front of the detector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   intr       : raw source
//   mode       : 1 = edge, 0 = level
//   pol        : 1 = rising/high, 0 = falling/low
//   armed      : edge detection enable (low right after reset release)
//   clr        : acknowledge pulse for this bit
//   isr        : status bit
module axi_lite_intc_src (
  input  logic clk,
  input  logic rst_n,
  input  logic intr,
  input  logic mode,
  input  logic pol,
  input  logic armed,
  input  logic clr,
  output logic isr
);

  logic src_s;
  logic dly_r;
  logic event_s;
  logic isr_r;

`ifdef INTC_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-flop synchroniser for an asynchronous source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= intr;
      sync2_r <= sync1_r;
    end
  end

  assign src_s = sync2_r;
`else
  assign src_s = intr;
`endif

  // Previous-cycle copy of the source for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_r <= 1'b0;
    end else begin
      dly_r <= src_s;
    end
  end

  // Event detection; edges are masked until the detector is armed.
  always_comb begin
    event_s = 1'b0;
    if (mode) begin
      if (pol) begin
        event_s = armed & src_s & ~dly_r;
      end else begin
        event_s = armed & ~src_s & dly_r;
      end
    end else begin
      event_s = (src_s == pol);
    end
  end

  // Status bit: a new event beats a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr_r <= 1'b0;
    end else begin
      isr_r <= event_s | (isr_r & ~clr);
    end
  end

  assign isr = isr_r;

endmodule

// File: rtl/axi_lite_intc.sv
// axi_lite_intc
// AXI4-Lite interrupt controller slave, up to 32 sources, one irq output.
// Registers: GIE 0x00, IER 0x04, ISR 0x08, IAR 0x0C, IPR 0x10, MODE 0x14,
// POL 0x18; offset 0x1C answers SLVERR.
// Build option: INTC_SYNC_EN enables a two-flop synchroniser per source.
// Ports:
//   ACLK, ARESETN    : clock, asynchronous active-low reset
//   intr_in          : raw interrupt sources
//   irq              : interrupt output, active level IRQ_ACTIVE_STATE
//   S_AXI_*          : AXI4-Lite slave (AWPROT/ARPROT ignored)
module axi_lite_intc
  import axi_lite_intc_pkg::*;
#(
  parameter int NUM_INTR         = 1,
  parameter int ADDR_WIDTH       = 5,
  parameter bit IRQ_ACTIVE_STATE = 1'b1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [NUM_INTR-1:0]   intr_in,
  output logic                  irq,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

`ifdef INTC_SYNC_EN
  // Edges stay masked until the synchroniser and delay flop hold real data.
  localparam logic [1:0] ARM_CYCLES = 2'd3;
`else
  localparam logic [1:0] ARM_CYCLES = 2'd1;
`endif

  logic                  gie_r;
  logic [NUM_INTR-1:0]   ier_r;
  logic [NUM_INTR-1:0]   mode_r;
  logic [NUM_INTR-1:0]   pol_r;
  logic [NUM_INTR-1:0]   isr_s;
  logic [NUM_INTR-1:0]   clr_s;
  logic [1:0]            arm_cnt_r;
  logic                  armed_s;

  logic                  awready_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic                  arready_r;
  logic                  rvalid_r;
  logic [1:0]            rresp_r;
  logic [31:0]           rdata_r;
  logic                  irq_r;

  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [2:0]            wr_idx_s;
  logic [2:0]            rd_idx_s;
  logic [31:0]           wmask_s;
  logic [31:0]           wdata_m_s;
  logic [1:0]            wr_resp_s;
  logic [31:0]           rd_data_s;
  logic [1:0]            rd_resp_s;
  logic                  irq_int_s;
  logic                  unused_s;

  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

  assign wr_en_s   = awready_r & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en_s   = arready_r & S_AXI_ARVALID;
  assign wr_idx_s  = S_AXI_AWADDR[4:2];
  assign rd_idx_s  = S_AXI_ARADDR[4:2];
  assign wmask_s   = strb_mask(S_AXI_WSTRB);
  assign wdata_m_s = S_AXI_WDATA & wmask_s;
  assign armed_s   = (arm_cnt_r == ARM_CYCLES);

  // Acknowledge pulse, only on the write handshake edge.
  always_comb begin
    clr_s = {NUM_INTR{1'b0}};
    if (wr_en_s && (wr_idx_s == REG_IAR)) begin
      clr_s = wdata_m_s[NUM_INTR-1:0];
    end else begin
      clr_s = {NUM_INTR{1'b0}};
    end
  end

  for (genvar i = 0; i < NUM_INTR; i++) begin : g_src
    axi_lite_intc_src u_src (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .intr  (intr_in[i]),
      .mode  (mode_r[i]),
      .pol   (pol_r[i]),
      .armed (armed_s),
      .clr   (clr_s[i]),
      .isr   (isr_s[i])
    );
  end

  // Counts cycles after reset release until edge detection is trusted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arm_cnt_r <= 2'd0;
    end else if (arm_cnt_r != ARM_CYCLES) begin
      arm_cnt_r <= arm_cnt_r + 2'd1;
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Write response code by address.
  always_comb begin
    wr_resp_s = RESP_OKAY;
    case (wr_idx_s)
      REG_GIE, REG_IER, REG_ISR, REG_IAR,
      REG_IPR, REG_MODE, REG_POL: wr_resp_s = RESP_OKAY;
      default:                    wr_resp_s = RESP_SLVERR;
    endcase
  end

  // Control registers with per-byte strobes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      gie_r  <= 1'b0;
      ier_r  <= {NUM_INTR{1'b0}};
      mode_r <= {NUM_INTR{1'b0}};
      pol_r  <= {NUM_INTR{1'b0}};
    end else if (wr_en_s) begin
      case (wr_idx_s)
        REG_GIE:  gie_r  <= S_AXI_WSTRB[0] ? S_AXI_WDATA[0] : gie_r;
        REG_IER:  ier_r  <= (ier_r  & ~wmask_s[NUM_INTR-1:0]) | wdata_m_s[NUM_INTR-1:0];
        REG_MODE: mode_r <= (mode_r & ~wmask_s[NUM_INTR-1:0]) | wdata_m_s[NUM_INTR-1:0];
        REG_POL:  pol_r  <= (pol_r  & ~wmask_s[NUM_INTR-1:0]) | wdata_m_s[NUM_INTR-1:0];
        default:  gie_r  <= gie_r;
      endcase
    end
  end

  // Write channel: one-cycle AW/W ready pulse, response held until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_r <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      awready_r <= S_AXI_AWVALID & S_AXI_WVALID & ~awready_r & ~bvalid_r;
      if (wr_en_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_resp_s;
      end else if (bvalid_r && S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read data mux; ISR/IPR are sampled before any same-edge write lands.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (rd_idx_s)
      REG_GIE:  rd_data_s[0]            = gie_r;
      REG_IER:  rd_data_s[NUM_INTR-1:0] = ier_r;
      REG_ISR:  rd_data_s[NUM_INTR-1:0] = isr_s;
      REG_IAR:  rd_data_s               = 32'h0000_0000;
      REG_IPR:  rd_data_s[NUM_INTR-1:0] = isr_s & ier_r;
      REG_MODE: rd_data_s[NUM_INTR-1:0] = mode_r;
      REG_POL:  rd_data_s[NUM_INTR-1:0] = pol_r;
      default:  rd_resp_s               = RESP_SLVERR;
    endcase
  end

  // Read channel: one-cycle AR ready pulse, data held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 32'h0000_0000;
    end else begin
      arready_r <= S_AXI_ARVALID & ~arready_r & ~rvalid_r;
      if (rd_en_s) begin
        rvalid_r <= 1'b1;
        rresp_r  <= rd_resp_s;
        rdata_r  <= rd_data_s;
      end else if (rvalid_r && S_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign irq_int_s = gie_r & (|(isr_s & ier_r));

  // Registered interrupt output at the configured active level.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_r <= ~IRQ_ACTIVE_STATE;
    end else begin
      irq_r <= IRQ_ACTIVE_STATE ? irq_int_s : ~irq_int_s;
    end
  end

  assign irq           = irq_r;
  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = awready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;

endmodule

// File: tb/tb_axi_lite_intc.sv
// tb_axi_lite_intc
// Directed self-checking bench for axi_lite_intc with NUM_INTR=4, irq active high.
module tb_axi_lite_intc;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  intr_in;
  logic        irq;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;

  axi_lite_intc #(.NUM_INTR(4), .ADDR_WIDTH(5), .IRQ_ACTIVE_STATE(1'b1)) dut (
    .ACLK(aclk), .ARESETN(aresetn), .intr_in(intr_in), .irq(irq),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Present AW+W, wait for the ready pulse, then wait for the response.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h awready=%b required=1", a, awready);
    end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge aclk);
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL bvalid_timeout addr=%h bvalid=%b required=1", a, bvalid);
    end
    resp = bresp;
    @(posedge aclk);
  endtask

  // Present AR, wait for the ready pulse, then capture the read data.
  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h arready=%b required=1", a, arready);
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge aclk);
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL rvalid_timeout addr=%h rvalid=%b required=1", a, rvalid);
    end
    d = rdata; resp = rresp;
    @(posedge aclk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    intr_in = 4'hF; aresetn = 1'b0;
    awaddr = 5'h00; awprot = 3'b000; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    araddr = 5'h00; arprot = 3'b000; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({irq, awready, wready, arready, bvalid, rvalid} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=000000",
               {irq, awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      failures++;
      $display("FAIL reset_resp_data got=%h required=0", {bresp, rresp, rdata});
    end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 7; i++) begin
      axi_read(5'(i * 4), d, r);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdata reg=%0d got=%h required=00000000", i, d);
      end
      checks++;
      if (r !== 2'b00) begin
        failures++;
        $display("FAIL reset_rresp reg=%0d got=%b required=00", i, r);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b required=0", irq);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h14, 32'hF, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL edge_mode_bresp got=%b required=00", r); end
    axi_write(5'h18, 32'hF, 4'hF, r);
    @(negedge aclk); intr_in = 4'h0;
    axi_write(5'h00, 32'h1, 4'hF, r);
    axi_write(5'h04, 32'hF, 4'hF, r);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL edge_isr_idle got=%h required=00000000", d); end
    @(negedge aclk); intr_in[2] = 1'b1;
    @(negedge aclk); intr_in[2] = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_early got=%b required=0", irq); end
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_latency got=%b required=1", irq); end
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL edge_isr got=%h required=00000004", d); end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL edge_ipr got=%h required=00000004", d); end
    axi_write(5'h0C, 32'h4, 4'hF, r);
    @(negedge aclk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL edge_ack_irq got=%b required=0", irq); end
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL edge_ack_isr got=%h required=00000000", d); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h14, 32'hE, 4'hF, r);
    axi_write(5'h18, 32'hE, 4'hF, r);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL level_isr got=%h required=00000001", d); end
    axi_write(5'h0C, 32'h1, 4'hF, r);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL level_reassert got=%h required=00000001", d); end
    @(negedge aclk); intr_in[0] = 1'b1;
    @(negedge aclk);
    axi_write(5'h0C, 32'h1, 4'hF, r);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL level_release got=%h required=00000000", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL level_irq got=%b required=0", irq); end
  endtask

  task automatic test_ier_mask();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h04, 32'h1, 4'hF, r);
    @(negedge aclk); intr_in[1] = 1'b1;
    @(negedge aclk); intr_in[1] = 1'b0;
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL mask_isr got=%h required=00000002", d); end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL mask_ipr got=%h required=00000000", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq got=%b required=0", irq); end
    axi_write(5'h04, 32'h3, 4'hF, r);
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL unmask_irq got=%b required=1", irq); end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL unmask_ipr got=%h required=00000002", d); end
    axi_write(5'h0C, 32'h2, 4'hF, r);
  endtask

  task automatic test_set_clear_collision();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    @(negedge aclk);
    awaddr = 5'h0C; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL collision_timeout awready=%b required=1", awready);
    end
    intr_in[1] = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk); intr_in[1] = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    @(posedge aclk);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL collision_isr got=%h required=00000002", d); end
    axi_write(5'h0C, 32'h2, 4'hF, r);
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL collision_cleanup got=%h required=00000000", d); end
  endtask

  task automatic test_slverr_backpressure();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL unmapped_bresp got=%b required=10", r); end
    axi_read(5'h1C, d, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL unmapped_rresp got=%b required=10", r); end
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped_rdata got=%h required=00000000", d); end
    bready = 1'b0;
    @(negedge aclk);
    awaddr = 5'h1C; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b10) begin
        failures++;
        $display("FAIL stall_bvalid cycle=%0d got=%b/%b required=1/10", i, bvalid, bresp);
      end
    end
    awaddr = 5'h04; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (awready !== 1'b0) begin
        failures++;
        $display("FAIL stall_awready cycle=%0d got=%b required=0", i, awready);
      end
    end
    bready = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (awready !== 1'b1) begin failures++; $display("FAIL resume_awready got=%b required=1", awready); end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge aclk);
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (bresp !== 2'b00 || bvalid !== 1'b1) begin
      failures++;
      $display("FAIL resume_bresp got=%b/%b required=1/00", bvalid, bresp);
    end
    @(posedge aclk);
    axi_read(5'h04, d, r);
    checks++;
    if (d !== 32'h5) begin failures++; $display("FAIL resume_ier got=%h required=00000005", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h04, 32'h0, 4'h0, r);
    axi_read(5'h04, d, r);
    checks++;
    if (d !== 32'h5) begin failures++; $display("FAIL strobe_none got=%h required=00000005", d); end
    axi_write(5'h14, 32'hFFFF_FFFF, 4'h1, r);
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL strobe_upper got=%h required=0000000f", d); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_ier_mask();
    test_set_clear_collision();
    test_slverr_backpressure();
    test_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
